// File: rtl/dm_sbus_bridge_pkg.sv
// Shared types for the debug-module slave-bus bridge: FSM states, grant
// encodings, the pending request record and the window-match helper.
package dm_sbus_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StRdata = 2'd2,
        StResp  = 2'd3
    } state_e;

    typedef enum logic {
        GntI = 1'b0,
        GntD = 1'b1
    } gnt_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    // Base is assumed aligned to the window, so only the upper bits matter.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned wbits);
        return (addr >> wbits) == (base >> wbits);
    endfunction

endpackage

// File: rtl/dm_sbus_arb.sv
// Two-request round-robin arbiter. The grant is combinational; last_grant
// only moves when the caller advances with at least one request pending.
module dm_sbus_arb
    import dm_sbus_bridge_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic fetch_req_i,
    input  logic data_req_i,
    input  logic advance_i,
    output gnt_e gnt_o
);

    gnt_e last_q;
    gnt_e gnt;

    always_comb begin
        gnt = GntI;
        if (fetch_req_i && data_req_i) begin
            gnt = (last_q == GntD) ? GntI : GntD;
        end else if (data_req_i) begin
            gnt = GntD;
        end
    end

    // Resetting to "data" lets fetch win the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= GntD;
        end else if (advance_i && (fetch_req_i || data_req_i)) begin
            last_q <= gnt;
        end
    end

    assign gnt_o = gnt;

endmodule

// File: rtl/dm_sbus_bridge.sv
// Bridges the core fetch and data strobe ports onto the single debug-module
// slave bus: pending capture, round-robin grant, window check, read sequencing.
module dm_sbus_bridge
    import dm_sbus_bridge_pkg::*;
#(
    parameter int unsigned BusWidth      = 32,
    parameter logic [31:0] DmBaseAddress = 32'h1000,
    parameter int unsigned WindowBits    = 12
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                i_strobe_i,
    input  logic [BusWidth-1:0] i_addr_i,
    output logic                i_ready_o,
    output logic [BusWidth-1:0] i_data_o,
    output logic                i_err_o,

    input  logic                d_strobe_i,
    input  logic                d_rw_i,
    input  logic [BusWidth-1:0] d_addr_i,
    input  logic [3:0]          d_be_i,
    input  logic [BusWidth-1:0] d_wdata_i,
    output logic                d_ready_o,
    output logic [BusWidth-1:0] d_data_o,
    output logic                d_err_o,

    output logic                dm_req_o,
    output logic                dm_we_o,
    output logic [BusWidth-1:0] dm_addr_o,
    output logic [3:0]          dm_be_o,
    output logic [BusWidth-1:0] dm_wdata_o,
    input  logic [BusWidth-1:0] dm_rdata_i
);

    logic        i_pend_q;
    logic [31:0] i_addr_q;
    logic        d_pend_q;
    req_t        d_req_q;

    state_e      state_q;
    gnt_e        gnt;
    gnt_e        gnt_q;
    logic        cur_we_q;
    req_t        sel_req;
    logic        sel_in_win;

    logic        dm_req_q;
    logic        dm_we_q;
    logic [31:0] dm_addr_q;
    logic [3:0]  dm_be_q;
    logic [31:0] dm_wdata_q;

    logic        i_ready_q;
    logic [31:0] i_data_q;
    logic        i_err_q;
    logic        d_ready_q;
    logic [31:0] d_data_q;
    logic        d_err_q;

    dm_sbus_arb u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fetch_req_i (i_pend_q),
        .data_req_i  (d_pend_q),
        .advance_i   (state_q == StIdle),
        .gnt_o       (gnt)
    );

    // Fetches and data reads present as full-word reads with no write data.
    always_comb begin
        sel_req = '0;
        if (gnt == GntD) begin
            sel_req = d_req_q;
            if (!d_req_q.we) begin
                sel_req.be    = 4'hF;
                sel_req.wdata = '0;
            end
        end else begin
            sel_req.addr = i_addr_q;
            sel_req.be   = 4'hF;
        end
        sel_in_win = addr_in_window(sel_req.addr, DmBaseAddress, WindowBits);
    end

    // A strobe landing on an already-pending port is dropped with its fields.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            i_pend_q <= 1'b0;
            i_addr_q <= '0;
            d_pend_q <= 1'b0;
            d_req_q  <= '0;
        end else begin
            if (i_strobe_i && !i_pend_q) begin
                i_pend_q <= 1'b1;
                i_addr_q <= i_addr_i;
            end else if (state_q == StResp && gnt_q == GntI) begin
                i_pend_q <= 1'b0;
            end
            if (d_strobe_i && !d_pend_q) begin
                d_pend_q <= 1'b1;
                d_req_q  <= '{we: d_rw_i, addr: d_addr_i, be: d_be_i, wdata: d_wdata_i};
            end else if (state_q == StResp && gnt_q == GntD) begin
                d_pend_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            gnt_q      <= GntI;
            cur_we_q   <= 1'b0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_be_q    <= '0;
            dm_wdata_q <= '0;
            i_ready_q  <= 1'b0;
            i_data_q   <= '0;
            i_err_q    <= 1'b0;
            d_ready_q  <= 1'b0;
            d_data_q   <= '0;
            d_err_q    <= 1'b0;
        end else begin
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_be_q    <= '0;
            dm_wdata_q <= '0;
            i_ready_q  <= 1'b0;
            d_ready_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_pend_q || d_pend_q) begin
                        gnt_q    <= gnt;
                        cur_we_q <= sel_req.we;
                        if (sel_in_win) begin
                            state_q    <= StIssue;
                            dm_req_q   <= 1'b1;
                            dm_we_q    <= sel_req.we;
                            dm_addr_q  <= {sel_req.addr[31:2], 2'b00};
                            dm_be_q    <= sel_req.be;
                            dm_wdata_q <= sel_req.wdata;
                        end else begin
                            state_q <= StResp;
                            if (gnt == GntI) begin
                                i_ready_q <= 1'b1;
                                i_err_q   <= 1'b1;
                                i_data_q  <= '0;
                            end else begin
                                d_ready_q <= 1'b1;
                                d_err_q   <= 1'b1;
                                d_data_q  <= '0;
                            end
                        end
                    end
                end
                StIssue: begin
                    // Writes complete without waiting on read data.
                    if (cur_we_q) begin
                        state_q   <= StResp;
                        d_ready_q <= 1'b1;
                        d_err_q   <= 1'b0;
                    end else begin
                        state_q <= StRdata;
                    end
                end
                StRdata: begin
                    state_q <= StResp;
                    if (gnt_q == GntI) begin
                        i_ready_q <= 1'b1;
                        i_err_q   <= 1'b0;
                        i_data_q  <= dm_rdata_i;
                    end else begin
                        d_ready_q <= 1'b1;
                        d_err_q   <= 1'b0;
                        d_data_q  <= dm_rdata_i;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign i_ready_o  = i_ready_q;
    assign i_data_o   = i_data_q;
    assign i_err_o    = i_err_q;
    assign d_ready_o  = d_ready_q;
    assign d_data_o   = d_data_q;
    assign d_err_o    = d_err_q;
    assign dm_req_o   = dm_req_q;
    assign dm_we_o    = dm_we_q;
    assign dm_addr_o  = dm_addr_q;
    assign dm_be_o    = dm_be_q;
    assign dm_wdata_o = dm_wdata_q;

endmodule

// File: tb/tb_dm_sbus_bridge.sv
// Directed plus randomized bench for dm_sbus_bridge with a slave model and a
// per-transaction reference model derived from latency and window rules.
module tb_dm_sbus_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        i_strobe_i;
    logic [31:0] i_addr_i;
    logic        i_ready_o;
    logic [31:0] i_data_o;
    logic        i_err_o;
    logic        d_strobe_i;
    logic        d_rw_i;
    logic [31:0] d_addr_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_wdata_i;
    logic        d_ready_o;
    logic [31:0] d_data_o;
    logic        d_err_o;
    logic        dm_req_o;
    logic        dm_we_o;
    logic [31:0] dm_addr_o;
    logic [3:0]  dm_be_o;
    logic [31:0] dm_wdata_o;
    logic [31:0] dm_rdata_i = 32'hDEAD_BEEF;

    dm_sbus_bridge dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_strobe_i (i_strobe_i),
        .i_addr_i   (i_addr_i),
        .i_ready_o  (i_ready_o),
        .i_data_o   (i_data_o),
        .i_err_o    (i_err_o),
        .d_strobe_i (d_strobe_i),
        .d_rw_i     (d_rw_i),
        .d_addr_i   (d_addr_i),
        .d_be_i     (d_be_i),
        .d_wdata_i  (d_wdata_i),
        .d_ready_o  (d_ready_o),
        .d_data_o   (d_data_o),
        .d_err_o    (d_err_o),
        .dm_req_o   (dm_req_o),
        .dm_we_o    (dm_we_o),
        .dm_addr_o  (dm_addr_o),
        .dm_be_o    (dm_be_o),
        .dm_wdata_o (dm_wdata_o),
        .dm_rdata_i (dm_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] slave_word(input logic [31:0] a);
        if (a == 32'h1800) return 32'h0010_0073;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Slave returns read data the cycle after a read request, garbage otherwise.
    always @(posedge clk_i)
        dm_rdata_i <= (dm_req_o && !dm_we_o) ? slave_word(dm_addr_o) : 32'hDEAD_BEEF;

    int unsigned req_cnt = 0, req_cyc = 0, i_cnt = 0, i_cyc = 0, d_cnt = 0, d_cyc = 0;
    int unsigned idle_viol = 0;
    logic        req_we;
    logic [31:0] req_addr, req_wdata, i_dat, d_dat;
    logic [3:0]  req_be;
    logic        i_er, d_er;

    always @(negedge clk_i) begin
        if (dm_req_o) begin
            req_cnt   <= req_cnt + 1;
            req_cyc   <= cyc;
            req_we    <= dm_we_o;
            req_addr  <= dm_addr_o;
            req_be    <= dm_be_o;
            req_wdata <= dm_wdata_o;
        end else if (dm_we_o || dm_addr_o != 0 || dm_be_o != 0 || dm_wdata_o != 0) begin
            idle_viol <= idle_viol + 1;
        end
        if (i_ready_o) begin
            i_cnt <= i_cnt + 1;
            i_cyc <= cyc;
            i_dat <= i_data_o;
            i_er  <= i_err_o;
        end
        if (d_ready_o) begin
            d_cnt <= d_cnt + 1;
            d_cyc <= cyc;
            d_dat <= d_data_o;
            d_er  <= d_err_o;
        end
    end

    int unsigned n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic strobe_i(input logic [31:0] a, output int unsigned t0);
        @(posedge clk_i); #1;
        i_strobe_i = 1'b1; i_addr_i = a; t0 = cyc;
        @(posedge clk_i); #1;
        i_strobe_i = 1'b0; i_addr_i = $urandom;
    endtask

    task automatic strobe_d(input logic rw, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd, output int unsigned t0);
        @(posedge clk_i); #1;
        d_strobe_i = 1'b1; d_rw_i = rw; d_addr_i = a; d_be_i = be; d_wdata_i = wd; t0 = cyc;
        @(posedge clk_i); #1;
        d_strobe_i = 1'b0; d_rw_i = $urandom; d_addr_i = $urandom; d_wdata_i = $urandom;
    endtask

    task automatic strobe_both(input logic [31:0] ia, input logic [31:0] da,
                               output int unsigned t0);
        @(posedge clk_i); #1;
        i_strobe_i = 1'b1; i_addr_i = ia; d_strobe_i = 1'b1; d_rw_i = 1'b0; d_addr_i = da;
        d_be_i = 4'h1; t0 = cyc;
        @(posedge clk_i); #1;
        i_strobe_i = 1'b0; d_strobe_i = 1'b0;
    endtask

    task automatic wait_rdy(input bit is_d, input int unsigned base, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_i); #1;
            if ((is_d ? d_cnt : i_cnt) != base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int unsigned t0, r0, ib, db;
        bit          ok, ok2;
        logic [31:0] a, wd;
        logic [3:0]  be;
        bit          port_d, rw, inwin;
        int unsigned lat;

        rst_i = 1'b1; i_strobe_i = 1'b0; i_addr_i = '0; d_strobe_i = 1'b0; d_rw_i = 1'b0;
        d_addr_i = '0; d_be_i = '0; d_wdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("reset_outs", {i_ready_o, i_err_o, d_ready_o, d_err_o, dm_req_o, dm_we_o, dm_be_o},
            '0);
        chk("reset_data", i_data_o | d_data_o | dm_addr_o | dm_wdata_o, '0);

        // Fetch read
        r0 = req_cnt; ib = i_cnt;
        strobe_i(32'h1800, t0);
        wait_rdy(1'b0, ib, ok);
        chk("fetch_ready_seen", ok, 1);
        chk("fetch_req_cyc", req_cyc - t0, 2);
        chk("fetch_req_addr", req_addr, 32'h1800);
        chk("fetch_req_be", req_be, 4'hF);
        chk("fetch_req_we", req_we, 0);
        chk("fetch_rdy_cyc", i_cyc - t0, 4);
        chk("fetch_data", i_dat, 32'h0010_0073);
        chk("fetch_err", i_er, 0);
        chk("fetch_req_count", req_cnt - r0, 1);

        // Data write with sub-word address
        r0 = req_cnt; db = d_cnt;
        strobe_d(1'b1, 32'h1382, 4'h3, 32'hBEEF, t0);
        wait_rdy(1'b1, db, ok);
        chk("wr_ready_seen", ok, 1);
        chk("wr_req_cyc", req_cyc - t0, 2);
        chk("wr_req_we", req_we, 1);
        chk("wr_req_addr", req_addr, 32'h1380);
        chk("wr_req_be", req_be, 4'h3);
        chk("wr_req_wdata", req_wdata, 32'hBEEF);
        chk("wr_rdy_cyc", d_cyc - t0, 3);

        // Out of window
        r0 = req_cnt; db = d_cnt;
        strobe_d(1'b0, 32'h8000_0000, 4'hF, 32'h0, t0);
        wait_rdy(1'b1, db, ok);
        chk("oow_ready_seen", ok, 1);
        chk("oow_no_req", req_cnt - r0, 0);
        chk("oow_rdy_cyc", d_cyc - t0, 2);
        chk("oow_err", d_er, 1);
        chk("oow_data", d_dat, 0);

        // Simultaneous pair: last grant was data, so fetch goes first
        ib = i_cnt; db = d_cnt;
        strobe_both(32'h1800, 32'h1380, t0);
        wait_rdy(1'b0, ib, ok);
        wait_rdy(1'b1, db, ok2);
        chk("pair1_both_done", {ok, ok2}, 2'b11);
        chk("pair1_fetch_first", i_cyc < d_cyc, 1);
        chk("pair1_fetch_lat", i_cyc - t0, 4);
        chk("pair1_d_data", d_dat, slave_word(32'h1380));

        // Re-strobe while pending is dropped
        r0 = req_cnt; ib = i_cnt;
        strobe_i(32'h1800, t0);
        i_strobe_i = 1'b1; i_addr_i = 32'h1900;
        @(posedge clk_i); #1;
        i_strobe_i = 1'b0;
        repeat (10) @(negedge clk_i);
        chk("restrobe_req_count", req_cnt - r0, 1);
        chk("restrobe_addr", req_addr, 32'h1800);
        chk("restrobe_ready_count", i_cnt - ib, 1);

        // Second pair: fetch was just served, so data goes first
        ib = i_cnt; db = d_cnt;
        strobe_both(32'h1800, 32'h1380, t0);
        wait_rdy(1'b0, ib, ok);
        wait_rdy(1'b1, db, ok2);
        chk("pair2_both_done", {ok, ok2}, 2'b11);
        chk("pair2_data_first", d_cyc < i_cyc, 1);
        chk("pair2_d_lat", d_cyc - t0, 4);

        // Reset while in RDATA
        r0 = req_cnt; ib = i_cnt;
        strobe_i(32'h1800, t0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("rst_mid_outs", {i_ready_o, i_err_o, d_ready_o, d_err_o, dm_req_o, dm_we_o, dm_be_o},
            '0);
        chk("rst_mid_data", i_data_o | d_data_o | dm_addr_o | dm_wdata_o, '0);
        repeat (6) @(negedge clk_i);
        chk("rst_mid_no_ready", i_cnt - ib, 0);
        chk("rst_mid_one_req", req_cnt - r0, 1);
        db = d_cnt;
        strobe_d(1'b0, 32'h1380, 4'h0, 32'h0, t0);
        wait_rdy(1'b1, db, ok);
        chk("post_rst_seen", ok, 1);
        chk("post_rst_lat", d_cyc - t0, 4);
        chk("post_rst_data", d_dat, slave_word(32'h1380));

        // Randomized single transactions against the reference model
        for (int n = 0; n < 40; n++) begin
            port_d = 1'($urandom_range(0, 1));
            rw     = port_d ? 1'($urandom_range(0, 1)) : 1'b0;
            be     = 4'($urandom);
            wd     = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                a = $urandom;
                if ((a >> 12) == 32'h1) a = a ^ 32'h8000_0000;
            end else begin
                a = 32'h1000 | ($urandom & 32'hFFF);
            end
            inwin = (a >> 12) == (32'h1000 >> 12);
            lat   = !inwin ? 2 : (rw ? 3 : 4);
            r0 = req_cnt; ib = i_cnt; db = d_cnt;
            if (port_d) strobe_d(rw, a, be, wd, t0);
            else strobe_i(a, t0);
            wait_rdy(port_d, port_d ? db : ib, ok);
            chk("rnd_ready_seen", ok, 1);
            chk("rnd_latency", (port_d ? d_cyc : i_cyc) - t0, lat);
            chk("rnd_err", port_d ? d_er : i_er, !inwin);
            chk("rnd_req_count", req_cnt - r0, inwin ? 1 : 0);
            if (!rw) chk("rnd_data", port_d ? d_dat : i_dat, inwin ? slave_word(a & ~32'h3) : 0);
            if (inwin) begin
                chk("rnd_req_addr", req_addr, a & ~32'h3);
                chk("rnd_req_we", req_we, rw);
                chk("rnd_req_be", req_be, rw ? be : 4'hF);
                chk("rnd_req_wdata", req_wdata, rw ? wd : 0);
            end
        end

        chk("idle_fields_zero", idle_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
